// File: rtl/bram_byte_lsu.sv
// Byte-serial load/store engine for an 8-bit-wide synchronous BRAM port.
// Optional misalignment trap is enabled by defining LSU_ALIGN_CHECK_EN.
module bram_byte_lsu #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  // Handshake: a request is taken on a cycle where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with
  // no backpressure.
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              misaligned;
  logic              last_issue;
  logic [1:0]        size_last;
  logic [1:0]        k, k_nxt, k_prev;
  logic [1:0]        last_q;
  logic              we_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_buf;
  logic [31:0]       assembled;
  logic [31:0]       load_result;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign size_last  = (req_size == 2'b00) ? 2'd0 :
                      (req_size == 2'b01) ? 2'd1 : 2'd3;
  assign last_issue = (k == last_q);
  assign k_nxt      = k + 2'd1;
  assign k_prev     = k - 2'd1;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misaligned ? RESP : XFER;
      XFER:    if (last_issue) state_nxt = we_q ? RESP : DRAIN;
      DRAIN:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final read byte arrives in DRAIN; merge it before extension.
  always_comb begin
    assembled = rd_buf;
    assembled[{last_q, 3'b000} +: 8] = mem_dout;
    case (last_q)
      2'd0:    load_result = uns_q ? {24'h0, assembled[7:0]}
                                   : {{24{assembled[7]}}, assembled[7:0]};
      2'd1:    load_result = uns_q ? {16'h0, assembled[15:0]}
                                   : {{16{assembled[15]}}, assembled[15:0]};
      default: load_result = assembled;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= 2'd0;
      last_q    <= 2'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      rd_buf    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            k       <= 2'd0;
            last_q  <= size_last;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_buf  <= 32'h0;
            if (misaligned) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b1;
            end else begin
              mem_en   <= 1'b1;
              mem_we   <= req_we;
              mem_addr <= req_addr;
              mem_din  <= req_wdata[7:0];
            end
          end
        end
        XFER: begin
          // Byte k-1 was issued last cycle and is on mem_dout now.
          if (!we_q && (k != 2'd0)) rd_buf[{k_prev, 3'b000} +: 8] <= mem_dout;
          if (last_issue) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (we_q) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b0;
            end
          end else begin
            k        <= k_nxt;
            mem_addr <= addr_q + ADDR_W'(k_nxt);
            mem_din  <= wdata_q[{k_nxt, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          rd_buf    <= assembled;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_result;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          rsp_valid <= 1'b0;
        end
        default: begin
          rsp_valid <= 1'b0;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_byte_lsu.sv
// Directed bench for bram_byte_lsu: a BRAM model, a transaction-level
// reference model scheduling expected per-cycle outputs, and a compare process.
module tb_bram_byte_lsu;
  localparam int AW   = 12;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;

  logic [7:0]    bram [4096];
  logic [7:0]    ref_mem [4096];
  logic          pre_clr, pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  chk_on = 1'b0;

  bit          exp_rdy [MAXC];
  bit          exp_en  [MAXC];
  bit          exp_we  [MAXC];
  bit [AW-1:0] exp_addr[MAXC];
  bit [7:0]    exp_din [MAXC];
  bit          exp_rv  [MAXC];
  bit [31:0]   exp_rd  [MAXC];
  bit          exp_err [MAXC];

  bram_byte_lsu #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Clock/reset and the byte BRAM (read-first, registered output)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_clr) begin
      for (int i = 0; i < 4096; i++) bram[i] <= 8'h00;
    end else if (pre_we) begin
      bram[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_din;
      mem_dout <= bram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_exp(input int from);
    for (int i = from; i < MAXC; i++) begin
      exp_rdy[i] = 1'b1; exp_en[i] = 1'b0; exp_we[i] = 1'b0; exp_addr[i] = '0;
      exp_din[i] = 8'h0; exp_rv[i] = 1'b0; exp_rd[i] = 32'h0; exp_err[i] = 1'b0;
    end
  endtask

  // Scoreboard: compare every cycle against the scheduled expectations
  always @(negedge clk) begin
    if (chk_on && rst_n && cyc < MAXC) begin
      chk("req_ready", {31'h0, req_ready}, {31'h0, exp_rdy[cyc]});
      chk("mem_en", {31'h0, mem_en}, {31'h0, exp_en[cyc]});
      if (exp_en[cyc]) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we[cyc]});
        chk("mem_addr", {20'h0, mem_addr}, {20'h0, exp_addr[cyc]});
        chk("mem_din", {24'h0, mem_din}, {24'h0, exp_din[cyc]});
      end
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rv[cyc]});
      if (exp_rv[cyc]) begin
        chk("rsp_rdata", rsp_rdata, exp_rd[cyc]);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err[cyc]});
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
    pre_addr = a; pre_data = v; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = v;
  endtask

  // Reference model: schedules expected bus/response cycles from the
  // request alone, then drives the request (with optional busy-time noise).
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input bit junk, output logic [31:0] rdata, output logic err);
    int c, n, r;
    bit mis;
    logic [31:0] raw, rd;
    logic [AW-1:0] a;
    c = cyc;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`endif
    raw = 32'h0;
    if (mis) begin
      r = c + 1;
      exp_rdy[r] = 1'b0; exp_rv[r] = 1'b1; exp_rd[r] = 32'h0; exp_err[r] = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        a = addr + AW'(k);
        exp_en[c+1+k] = 1'b1; exp_we[c+1+k] = we; exp_addr[c+1+k] = a;
        exp_din[c+1+k] = wdata[8*k +: 8];
        raw[8*k +: 8] = ref_mem[a];
        if (we) ref_mem[a] = wdata[8*k +: 8];
      end
      case (size)
        2'b00:   rd = uns ? {24'h0, raw[7:0]} : 32'($signed(raw[7:0]));
        2'b01:   rd = uns ? {16'h0, raw[15:0]} : 32'($signed(raw[15:0]));
        default: rd = raw;
      endcase
      r = we ? c + n + 1 : c + n + 2;
      for (int i = c + 1; i <= r; i++) exp_rdy[i] = 1'b0;
      exp_rv[r] = 1'b1; exp_rd[r] = we ? 32'h0 : rd; exp_err[r] = 1'b0;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = junk;
    req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_addr = AW'($urandom_range(0, 4095)); req_wdata = $urandom;
    while (cyc < r) @(negedge clk);
    req_valid = 1'b0;
    rdata = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    clear_exp(0);
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0;
    pre_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = 8'h0;
    @(negedge clk);
    pre_clr = 1'b0;
    chk("reset req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset mem_en", {31'h0, mem_en}, 32'h0);
    chk("reset mem_addr", {20'h0, mem_addr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;

    // Word store then load back
    do_req(1'b1, 2'b10, 1'b0, 12'h0C8, 32'h0C800093, 1'b1, rd, er);
    chk("sw byte0", {24'h0, bram[12'h0C8]}, 32'h93);
    chk("sw byte1", {24'h0, bram[12'h0C9]}, 32'h00);
    chk("sw byte2", {24'h0, bram[12'h0CA]}, 32'h80);
    chk("sw byte3", {24'h0, bram[12'h0CB]}, 32'h0C);
    do_req(1'b0, 2'b10, 1'b0, 12'h0C8, 32'h0, 1'b0, rd, er);
    chk("lw data", rd, 32'h0C800093);

    // Byte and half extension
    preload(12'h100, 8'h80);
    do_req(1'b0, 2'b00, 1'b0, 12'h100, 32'h0, 1'b1, rd, er);
    chk("lb data", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 12'h100, 32'h0, 1'b0, rd, er);
    chk("lbu data", rd, 32'h00000080);
    preload(12'h200, 8'h01);
    preload(12'h201, 8'h80);
    do_req(1'b0, 2'b01, 1'b0, 12'h200, 32'h0, 1'b0, rd, er);
    chk("lh data", rd, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 12'h200, 32'h0, 1'b1, rd, er);
    chk("lhu data", rd, 32'h00008001);

    // Wrap-around word store / load at the top of the address space
    do_req(1'b1, 2'b10, 1'b0, 12'hFFE, 32'hAABBCCDD, 1'b0, rd, er);
`ifndef LSU_ALIGN_CHECK_EN
    chk("wrap err", {31'h0, er}, 32'h0);
    chk("wrap FFE", {24'h0, bram[12'hFFE]}, 32'hDD);
    chk("wrap FFF", {24'h0, bram[12'hFFF]}, 32'hCC);
    chk("wrap 000", {24'h0, bram[12'h000]}, 32'hBB);
    chk("wrap 001", {24'h0, bram[12'h001]}, 32'hAA);
`endif
    do_req(1'b0, 2'b10, 1'b0, 12'hFFE, 32'h0, 1'b0, rd, er);

    // Misaligned word load, then aligned load
    preload(12'h0CC, 8'h11);
    do_req(1'b0, 2'b10, 1'b0, 12'h0C9, 32'h0, 1'b0, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis data", rd, 32'h0);
    chk("mis err", {31'h0, er}, 32'h1);
`else
    chk("mis data", rd, 32'h110C8000);
    chk("mis err", {31'h0, er}, 32'h0);
`endif
    do_req(1'b0, 2'b10, 1'b0, 12'h0C8, 32'h0, 1'b0, rd, er);
    chk("aligned after mis", rd, 32'h0C800093);

    // Half/byte/reserved-size stores, then loads
    do_req(1'b1, 2'b01, 1'b0, 12'h400, 32'h1234FF7E, 1'b1, rd, er);
    chk("sh rdata zero", rd, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 12'h402, 32'hCAFE0099, 1'b0, rd, er);
    do_req(1'b1, 2'b11, 1'b0, 12'h404, 32'hDEADBEEF, 1'b1, rd, er);
    do_req(1'b0, 2'b10, 1'b1, 12'h400, 32'h0, 1'b0, rd, er);
    chk("lw mixed", rd, 32'h0099FF7E);
    do_req(1'b0, 2'b11, 1'b1, 12'h404, 32'h0, 1'b0, rd, er);
    chk("lw size11", rd, 32'hDEADBEEF);
    do_req(1'b0, 2'b01, 1'b0, 12'h401, 32'h0, 1'b0, rd, er);
`ifndef LSU_ALIGN_CHECK_EN
    chk("lh odd", rd, 32'hFFFF99FF);
`endif
    do_req(1'b0, 2'b01, 1'b1, 12'h402, 32'h0, 1'b1, rd, er);
    chk("lhu 402", rd, 32'h00000099);

    // Reset during byte 2 of a word store
    chk_on = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 12'h300; req_wdata = 32'h44332211;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst byte2 en", {31'h0, mem_en}, 32'h1);
    chk("rst byte2 addr", {20'h0, mem_addr}, 32'h302);
    rst_n = 1'b0;
    #1;
    chk("rst mid en", {31'h0, mem_en}, 32'h0);
    chk("rst mid we", {31'h0, mem_we}, 32'h0);
    chk("rst mid addr", {20'h0, mem_addr}, 32'h0);
    chk("rst mid din", {24'h0, mem_din}, 32'h0);
    chk("rst mid rv", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst no rsp", {31'h0, rsp_valid}, 32'h0);
    end
    chk("rst ready", {31'h0, req_ready}, 32'h1);
    chk("rst 300", {24'h0, bram[12'h300]}, 32'h11);
    chk("rst 301", {24'h0, bram[12'h301]}, 32'h22);
    chk("rst 302", {24'h0, bram[12'h302]}, 32'h00);
    ref_mem[12'h300] = 8'h11;
    ref_mem[12'h301] = 8'h22;
    clear_exp(cyc);
    chk_on = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 12'h300, 32'h0, 1'b0, rd, er);
    chk("load after rst", rd, 32'h00002211);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_byte_lsu.md
Name: bram_byte_lsu

Overview:
- Initiator-side access engine for the 8-bit-wide, 4096-deep dual-port byte BRAM used as instruction/data store.
- Converts one CPU load/store request (byte/half/word, little-endian) into a sequence of single-byte BRAM port cycles.
- Reassembles read bytes, then sign- or zero-extends them.
- Sits between the SCPU memory stage and one BRAM port (a or b).

Parameters:
- ADDR_W, 12, byte address width; matches BRAM depth 2^ADDR_W.

Ports:
- clk  in  1  single clock; BRAM port clock is driven from the same net.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address of the least significant byte.
- req_wdata  in  32  store data; low N bytes used.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores.
- rsp_err  out  1  misalignment error, valid with rsp_valid.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable (drives 1-bit we).
- mem_addr  out  ADDR_W  BRAM byte address.
- mem_din  out  8  BRAM write byte.
- mem_dout  in  8  BRAM read byte; registered in the BRAM, valid the cycle after mem_en.

Behaviour:
- Reset values (async, immediate):
  - State = IDLE, req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
  - Byte counters cleared.
- N = 1 / 2 / 4 for size 00 / 01 / {10, 11}. Request fields are latched at accept and are don't-care afterwards.
- States:
  - IDLE → XFER on accept.
  - XFER: issues byte k = 0..N-1, one per cycle, all BRAM outputs registered. Drives mem_en = 1, mem_addr = (addr + k) mod 2^ADDR_W, mem_we = we, mem_din = wdata[8k+7:8k].
  - After byte N-1: store → RESP; load → DRAIN.
  - DRAIN: one cycle to capture the last read byte. → RESP.
  - RESP: rsp_valid = 1 for exactly one cycle. → IDLE.
- Read capture:
  - Byte k appears on mem_dout the cycle after its issue and is stored into bits [8k+7:8k].
  - Bytes are captured in the XFER/DRAIN cycles following each issue.
- Timing, with accept at cycle T:
  - Issues occur in T+1 .. T+N.
  - Store: rsp_valid in T+N+1.
  - Load: rsp_valid in T+N+2.
  - mem_en = 0 in IDLE, DRAIN and RESP.
- Extension:
  - Size 00: bits [31:8] = unsigned ? 0 : {24{b0[7]}}.
  - Size 01: bits [31:16] = unsigned ? 0 : {16{b1[7]}}.
  - Word: no extension.
  - req_unsigned is ignored for words and stores.
- rsp_rdata holds its value until the next response. A store response drives rsp_rdata = 0.
- Address wrap-around: 0xFFF + 1 → 0x000 with no error.
- req_valid in a non-IDLE state is ignored; no queueing.
- Reset mid-operation: the transaction is abandoned, no response is produced, and bytes already written stay written.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - A half request with addr[0] != 0, or a word request with addr[1:0] != 0, issues no BRAM cycle.
  - FSM goes IDLE → RESP; rsp_valid with rsp_err = 1 and rsp_rdata = 0 in T+1.
  - Aligned requests behave as normal with rsp_err = 0.
- Not defined: rsp_err tied 0; misaligned accesses proceed byte-wise, including wrap.

Test Plan:
- Store word, addr 0x0C8, wdata 0x0C800093, sizes 10 → mem_we pulses at 0x0C8..0x0CB with din 93, 00, 80, 0C; rsp_valid in T+5. Then load word → rsp_rdata = 0x0C800093 in T+6.
- Preload byte 0x80 at 0x100: LB → 0xFFFFFF80; LBU → 0x00000080. Each response arrives in T+3.
- Preload 0x8001 at 0x200 (little-endian): LH → 0xFFFF8001; LHU → 0x00008001.
- Word store to 0xFFE, data 0xAABBCCDD → bytes land at 0xFFE=DD, 0xFFF=CC, 0x000=BB, 0x001=AA. Without the macro, rsp_err = 0.
- With LSU_ALIGN_CHECK_EN, load word at 0x0C9 → no mem_en pulse; rsp_valid in T+1 with rsp_err = 1 and rsp_rdata = 0. A following aligned load works normally.
- Assert rst_n low during byte 2 of a word store → outputs clear immediately with no rsp_valid; bytes 0–1 remain written and req_ready = 1 after release.
